ram_sync: RTL and testbench
===========================

// Module: ram_sync
//
// PURPOSE
// - Synchronous single-clock RAM, one write port and one read port. Successor to the
//   asynchronous RAM model: registered read, defined read-during-write and a
//   hardware clear engine in place of simulation-only initialisation.
// - Serves as CPU data/program memory.
// - Clear engine zeroes every location after reset, so contents are defined in
//   synthesis as well as in simulation.
//
// PARAMETERS
// - ADDR_BITS       16  address width; depth = 2**ADDR_BITS words
// - DATA_BITS        8  word width
// - RDW_MODE         0  same-address read+write in one cycle: 0 = old data, 1 = new data
// - CLEAR_ON_RESET   1  1 = zero all words after reset; 0 = skip clear, contents undefined
//
// PORTS
// - clk      in   1          clock; all activity on rising edge
// - reset    in   1          synchronous, active-high
// - busy     out  1          1 while clear engine runs; ports ignored
// - wr_en    in   1          write strobe
// - wr_addr  in   ADDR_BITS  write address
// - wr_data  in   DATA_BITS  write data
// - rd_en    in   1          read strobe
// - rd_addr  in   ADDR_BITS  read address
// - rd_data  out  DATA_BITS  registered read data
// - rd_valid out  1          1-cycle pulse: rd_data holds result of the prior rd_en
//
// BEHAVIOUR
// - States: CLEAR, READY. Reset sampled high at an edge: clr_cnt=0, rd_valid=0,
//   rd_data=0; state=CLEAR, busy=1 if CLEAR_ON_RESET, else state=READY, busy=0.
// - Reset has priority over all other inputs. Reset asserted mid-clear restarts the
//   clear at address 0. Reset in READY drops a pending rd_valid; memory keeps its
//   contents unless CLEAR_ON_RESET=1.
// - CLEAR: each edge writes 0 to mem[clr_cnt] and increments clr_cnt (ADDR_BITS wide).
//   The edge that writes address 2**ADDR_BITS-1 moves to READY and drops busy.
//   Clear takes exactly 2**ADDR_BITS cycles after reset deasserts. No counter wrap.
// - During CLEAR: wr_en and rd_en are ignored (no write, no read). rd_valid stays 0.
// - READY write: wr_en=1 at edge N -> mem[wr_addr]=wr_data after edge N.
// - READY read: rd_en=1 at edge N -> rd_data=mem[rd_addr] and rd_valid=1 after edge N.
//   Latency is 1 clock. rd_en=0 -> rd_valid=0 and rd_data holds its last value.
// - Read-during-write, same address, same edge:
//   - RDW_MODE=0: rd_data returns the pre-write word.
//   - RDW_MODE=1: rd_data returns wr_data (bypass).
//   Different addresses: the two ports are independent.
// - Back-to-back reads are allowed every cycle; throughput is 1 read and 1 write per clock.
// - No X on outputs after the first reset edge. Reads of uncleared memory
//   (CLEAR_ON_RESET=0) may return any value.
//
// TESTING (ADDR_BITS=4, DATA_BITS=8 unless noted)
// - Clear: reset for 1 cycle, then idle -> busy=1 for exactly 16 cycles.
//   Then reading addresses 0..15 returns 0x00 each, with rd_valid 1 cycle after each rd_en.
// - Write/read: write 0xA5 to address 3, rd_en at address 3 on the next edge ->
//   rd_data=0xA5, rd_valid=1 one cycle later. Idle cycle after that: rd_valid=0, rd_data
//   stays 0xA5.
// - Read-during-write: mem[7]=0x11. On one edge, write 0x22 to address 7 and read
//   address 7 -> RDW_MODE=0 returns 0x11; RDW_MODE=1 returns 0x22. Either mode, a
//   following read of address 7 returns 0x22.
// - Busy gating: during CLEAR, write 0xFF to address 2 and read address 2 ->
//   rd_valid stays 0. After busy falls, address 2 reads 0x00.
// - Reset mid-clear: reasserting reset at clear cycle 9 -> busy stays 1 for a full
//   16 cycles after reset deasserts; all addresses read 0x00.
// - No clear: CLEAR_ON_RESET=0 -> busy=0 on the first edge after reset. Write 0x3C
//   to address 15, then read it -> 0x3C.

Source files
------------

// File: rtl/ram_sync.sv
// Synchronous single-clock RAM with one write port, one registered read port and a
// hardware clear engine that zeroes every word after reset.
module ram_sync #(
    parameter int ADDR_BITS      = 16,
    parameter int DATA_BITS      = 8,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 busy,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [ADDR_BITS-1:0]   clr_cnt_r;
    logic                   clr_last_s;
    logic                   busy_r;
    logic                   rd_valid_r;
    logic [DATA_BITS-1:0]   rd_data_r;
    logic [DATA_BITS-1:0]   mem_r [DEPTH];

    logic                   mem_we_s;
    logic [ADDR_BITS-1:0]   mem_waddr_s;
    logic [DATA_BITS-1:0]   mem_wdata_s;
    logic                   rd_fire_s;
    logic                   rdw_hit_s;

    assign clr_last_s = (clr_cnt_r == {ADDR_BITS{1'b1}});

    // Next-state logic: clear runs until the last address has been written.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_last_s) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_READY: state_nxt_s = ST_READY;
            default:  state_nxt_s = ST_CLEAR;
        endcase
    end

    // Port arbitration: the clear engine owns the array; user ports only act in READY.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = wr_data;
        rd_fire_s   = 1'b0;
        rdw_hit_s   = 1'b0;
        if (reset) begin
            mem_we_s  = 1'b0;
            rd_fire_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_cnt_r;
            mem_wdata_s = {DATA_BITS{1'b0}};
        end else begin
            mem_we_s  = wr_en;
            rd_fire_s = rd_en;
            // New-data mode forwards the incoming word on a same-address collision.
            rdw_hit_s = (RDW_MODE != 0) && wr_en && (wr_addr == rd_addr);
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control state, clear counter and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            busy_r     <= (CLEAR_ON_RESET != 0);
            clr_cnt_r  <= {ADDR_BITS{1'b0}};
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DATA_BITS{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s == ST_CLEAR);
            rd_valid_r <= rd_fire_s;
            if ((state_r == ST_CLEAR) && !clr_last_s) begin
                clr_cnt_r <= clr_cnt_r + ADDR_BITS'(1);
            end
            // Array read samples the pre-write word, giving old-data behaviour by default.
            if (rd_fire_s) begin
                rd_data_r <= rdw_hit_s ? wr_data : mem_r[rd_addr];
            end
        end
    end

    assign busy     = busy_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_ram_sync.sv
// Self-checking bench for ram_sync: one instance with old-data RDW and clear enabled,
// one with new-data RDW and no clear, both checked against an array reference model.
module tb_ram_sync;

    localparam int AB = 4;
    localparam int DB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_a, wr_en_a, rd_en_a, busy_a, rd_valid_a;
    logic [AB-1:0] wr_addr_a, rd_addr_a;
    logic [DB-1:0] wr_data_a, rd_data_a;
    logic          reset_b, wr_en_b, rd_en_b, busy_b, rd_valid_b;
    logic [AB-1:0] wr_addr_b, rd_addr_b;
    logic [DB-1:0] wr_data_b, rd_data_b;

    ram_sync #(.ADDR_BITS(AB), .DATA_BITS(DB), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset(reset_a), .busy(busy_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    ram_sync #(.ADDR_BITS(AB), .DATA_BITS(DB), .RDW_MODE(1), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .reset(reset_b), .busy(busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    int tests = 0;
    int fails = 0;

    logic [DB-1:0] mem_a [16];
    logic [DB-1:0] mem_b [16];
    logic [DB-1:0] exp_da, exp_db;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        wr_en_a = 1'b0; rd_en_a = 1'b0;
        wr_en_b = 1'b0; rd_en_b = 1'b0;
    endtask

    // One READY-phase clock for both instances, predicted from the model arrays.
    task automatic cycle_ready;
        logic exp_va, exp_vb;
        exp_va = rd_en_a;
        exp_vb = rd_en_b;
        if (rd_en_a) exp_da = mem_a[rd_addr_a];
        if (rd_en_b) exp_db = (wr_en_b && wr_addr_b == rd_addr_b) ? wr_data_b : mem_b[rd_addr_b];
        if (wr_en_a) mem_a[wr_addr_a] = wr_data_a;
        if (wr_en_b) mem_b[wr_addr_b] = wr_data_b;
        step;
        check("busy_a_ready", 32'(busy_a), 32'd0);
        check("busy_b_ready", 32'(busy_b), 32'd0);
        check("rd_valid_a", 32'(rd_valid_a), 32'(exp_va));
        check("rd_valid_b", 32'(rd_valid_b), 32'(exp_vb));
        check("rd_data_a", 32'(rd_data_a), 32'(exp_da));
        check("rd_data_b", 32'(rd_data_b), 32'(exp_db));
    endtask

    // Watch a full clear on instance a; optionally hammer address 2 late in the clear.
    task automatic watch_clear(input bit gate);
        for (int i = 0; i < 16; i++) begin
            if (gate && i >= 10) begin
                wr_en_a = 1'b1; wr_addr_a = 4'd2; wr_data_a = 8'hFF;
                rd_en_a = 1'b1; rd_addr_a = 4'd2;
            end
            step;
            check("clear_busy", 32'(busy_a), (i < 15) ? 32'd1 : 32'd0);
            check("clear_rd_valid", 32'(rd_valid_a), 32'd0);
            check("clear_rd_data", 32'(rd_data_a), 32'd0);
        end
        idle_all;
        for (int a = 0; a < 16; a++) mem_a[a] = 8'h00;
        exp_da = 8'h00;
    endtask

    // Read every address of a (expect zero) while loading random words into b.
    task automatic sweep_a_fill_b;
        for (int a = 0; a < 16; a++) begin
            rd_en_a = 1'b1; rd_addr_a = AB'(a);
            wr_en_b = 1'b1; wr_addr_b = AB'(a); wr_data_b = DB'($urandom);
            cycle_ready;
            check("cleared_word", 32'(rd_data_a), 32'd0);
        end
        idle_all;
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        idle_all;
        wr_addr_a = 4'd0; rd_addr_a = 4'd0; wr_data_a = 8'd0;
        wr_addr_b = 4'd0; rd_addr_b = 4'd0; wr_data_b = 8'd0;
        step;
        check("rst_busy_a", 32'(busy_a), 32'd1);
        check("rst_valid_a", 32'(rd_valid_a), 32'd0);
        check("rst_data_a", 32'(rd_data_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_valid_b", 32'(rd_valid_b), 32'd0);
        check("rst_data_b", 32'(rd_data_b), 32'd0);
        exp_da = 8'h00; exp_db = 8'h00;
        reset_a = 1'b0; reset_b = 1'b0;

        watch_clear(1'b1);
        sweep_a_fill_b;
        cycle_ready;

        // Simple write then read, then an idle cycle holding the data.
        wr_en_a = 1'b1; wr_addr_a = 4'd3; wr_data_a = 8'hA5;
        cycle_ready;
        wr_en_a = 1'b0; rd_en_a = 1'b1; rd_addr_a = 4'd3;
        cycle_ready;
        check("wr_rd_a5", 32'(rd_data_a), 32'hA5);
        rd_en_a = 1'b0;
        cycle_ready;
        check("hold_a5", 32'(rd_data_a), 32'hA5);
        check("hold_valid", 32'(rd_valid_a), 32'd0);

        // Read-during-write at address 7 on both instances.
        wr_en_a = 1'b1; wr_addr_a = 4'd7; wr_data_a = 8'h11;
        wr_en_b = 1'b1; wr_addr_b = 4'd7; wr_data_b = 8'h11;
        cycle_ready;
        wr_data_a = 8'h22; rd_en_a = 1'b1; rd_addr_a = 4'd7;
        wr_data_b = 8'h22; rd_en_b = 1'b1; rd_addr_b = 4'd7;
        cycle_ready;
        check("rdw_old", 32'(rd_data_a), 32'h11);
        check("rdw_new", 32'(rd_data_b), 32'h22);
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        cycle_ready;
        check("rdw_after_a", 32'(rd_data_a), 32'h22);
        check("rdw_after_b", 32'(rd_data_b), 32'h22);
        idle_all;

        // No-clear instance: write 0x3C to the top address and read it back.
        wr_en_b = 1'b1; wr_addr_b = 4'd15; wr_data_b = 8'h3C;
        cycle_ready;
        wr_en_b = 1'b0; rd_en_b = 1'b1; rd_addr_b = 4'd15;
        cycle_ready;
        check("noclr_3c", 32'(rd_data_b), 32'h3C);

        // Reset in READY with reads pending: rd_valid dropped, b keeps contents.
        rd_en_a = 1'b1; rd_addr_a = 4'd3; rd_en_b = 1'b1; rd_addr_b = 4'd15;
        reset_a = 1'b1; reset_b = 1'b1;
        step;
        check("rrdy_valid_a", 32'(rd_valid_a), 32'd0);
        check("rrdy_valid_b", 32'(rd_valid_b), 32'd0);
        check("rrdy_data_a", 32'(rd_data_a), 32'd0);
        check("rrdy_busy_a", 32'(busy_a), 32'd1);
        check("rrdy_busy_b", 32'(busy_b), 32'd0);
        reset_a = 1'b0; reset_b = 1'b0;
        rd_en_a = 1'b0;
        step;
        check("keep_b_valid", 32'(rd_valid_b), 32'd1);
        check("keep_b_data", 32'(rd_data_b), 32'h3C);
        exp_db = 8'h3C;
        rd_en_b = 1'b0;
        for (int i = 0; i < 8; i++) step;
        check("midclr_busy", 32'(busy_a), 32'd1);

        // Reset again at clear cycle 9: the clear restarts from address 0.
        reset_a = 1'b1;
        step;
        check("midclr_rst_busy", 32'(busy_a), 32'd1);
        reset_a = 1'b0;
        watch_clear(1'b0);
        sweep_a_fill_b;

        // Randomised traffic with frequent same-address collisions.
        for (int n = 0; n < 300; n++) begin
            wr_en_a = 1'($urandom); wr_addr_a = AB'($urandom); wr_data_a = DB'($urandom);
            rd_en_a = 1'($urandom);
            rd_addr_a = ($urandom_range(2, 0) == 0) ? wr_addr_a : AB'($urandom);
            wr_en_b = 1'($urandom); wr_addr_b = AB'($urandom); wr_data_b = DB'($urandom);
            rd_en_b = 1'($urandom);
            rd_addr_b = ($urandom_range(2, 0) == 0) ? wr_addr_b : AB'($urandom);
            cycle_ready;
        end
        idle_all;
        cycle_ready;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
